clock_ui_ctrl: RTL

User-interface sequencer between the DE2 switches/keys and the clock/stopwatch/timer datapath. Synchronises and debounces KEY[3:1] and SW[3:0], and decodes the active mode. Translates key presses into single-cycle command pulses and run-enable levels for the datapath. Also generates the shared 1 Hz tick enable and the set-mode blink phase, so the datapath runs entirely on clk_50MHz with no derived clocks.

---
 rtl/clock_pkg.sv | 44 ++++
 rtl/key_debounce.sv | 60 ++++++
 rtl/clock_ui_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared encodings for the clock/stopwatch/timer user-interface sequencer:
// display modes, editable timer fields and the KEY[3] press classifier states.
package clock_pkg;

    typedef enum logic [2:0] {
        MODE_CLOCK      = 3'd0,
        MODE_CLOCK_SET  = 3'd1,
        MODE_STOPWATCH  = 3'd2,
        MODE_TIMER      = 3'd3,
        MODE_TIMER_SET  = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        FLD_H = 2'd0,
        FLD_M = 2'd1,
        FLD_S = 2'd2
    } field_e;

    typedef enum logic [1:0] {
        KEY_PRESS_IDLE      = 2'd0,
        KEY_PRESS_HELD      = 2'd1,
        KEY_PRESS_LONG_DONE = 2'd2
    } key_press_e;

    // Editing order cycles hours -> minutes -> seconds -> hours.
    function automatic field_e next_field(input field_e f);
        case (f)
            FLD_H:   return FLD_M;
            FLD_M:   return FLD_S;
            default: return FLD_H;
        endcase
    endfunction

    // One-hot increment vector ordered {hours, minutes, seconds}.
    function automatic logic [2:0] field_onehot(input field_e f);
        case (f)
            FLD_H:   return 3'b100;
            FLD_M:   return 3'b010;
            FLD_S:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-FF synchroniser plus debounce counter for one active-low push button;
// emits single-cycle pulses when the accepted level is pressed or released.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk_50MHz,
    input  logic reset,
    input  logic key_n,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The accepted level only flips after DEBOUNCE_CYC consecutive differing samples.
    always_comb begin
        cnt_d     = '0;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d   = sync2_q;
                press_d   = ~sync2_q;
                release_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            level_q   <= 1'b1;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= key_n;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: rtl/clock_ui_ctrl.sv
// User-interface sequencer: turns DE2 keys/switches into mode, command pulses
// and run levels for the clock datapath, plus the shared 1 Hz tick and blink phase.
module clock_ui_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int LONG_CYC     = 50_000_000
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic [2:0] key_n,
    input  logic [3:0] sw,
    input  logic       timer_done,
    output logic       tick_1hz,
    output logic [2:0] mode,
    output logic       inc_min,
    output logic       inc_hr,
    output logic       sw_run,
    output logic       sw_clr,
    output logic       tmr_run,
    output logic       tmr_clr,
    output logic [2:0] tmr_inc,
    output logic [1:0] field_sel,
    output logic       blink
);

    localparam int DIV_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int HOLD_W = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_HZ - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_HZ / 2);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);

    logic [2:0] key_press, key_release;
    logic       unused_release;

    for (genvar i = 0; i < 3; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_key (
            .clk_50MHz     (clk_50MHz),
            .reset         (reset),
            .key_n         (key_n[i]),
            .press_pulse   (key_press[i]),
            .release_pulse (key_release[i])
        );
    end

    // Only KEY[3] distinguishes short from long presses.
    assign unused_release = ^key_release[1:0];

    logic [3:0]        sw_sync1_q, sw_sync2_q;
    mode_e             mode_q, mode_d;
    key_press_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [DIV_W-1:0]  div_q, div_d;
    field_e            field_sel_q, field_sel_d;
    logic              tick_q, tick_d;
    logic              sw_run_q, sw_run_d, tmr_run_q, tmr_run_d;
    logic              sw_clr_q, sw_clr_d, tmr_clr_q, tmr_clr_d;
    logic              inc_min_q, inc_min_d, inc_hr_q, inc_hr_d;
    logic [2:0]        tmr_inc_q, tmr_inc_d;
    logic              mode_change, enter_tset, short_act, long_act;

    always_comb begin
        if (sw_sync2_q[1])      mode_d = MODE_STOPWATCH;
        else if (sw_sync2_q[2]) mode_d = sw_sync2_q[3] ? MODE_TIMER_SET : MODE_TIMER;
        else                    mode_d = sw_sync2_q[0] ? MODE_CLOCK_SET : MODE_CLOCK;
    end

    assign mode_change = (mode_d != mode_q);
    assign enter_tset  = mode_change && (mode_d == MODE_TIMER_SET);

    // KEY[3] classifier; any mode change abandons a hold without an action.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        short_act = 1'b0;
        long_act  = 1'b0;
        if (mode_change) begin
            state_d = KEY_PRESS_IDLE;
            hold_d  = '0;
        end else begin
            case (state_q)
                KEY_PRESS_IDLE: begin
                    if (key_press[2] && (mode_q == MODE_STOPWATCH || mode_q == MODE_TIMER)) begin
                        state_d = KEY_PRESS_HELD;
                        hold_d  = '0;
                    end
                end
                KEY_PRESS_HELD: begin
                    if (key_release[2]) begin
                        short_act = 1'b1;
                        state_d   = KEY_PRESS_IDLE;
                    end else if (hold_q == HOLD_LAST) begin
                        long_act = 1'b1;
                        state_d  = KEY_PRESS_LONG_DONE;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                KEY_PRESS_LONG_DONE: begin
                    if (key_release[2]) state_d = KEY_PRESS_IDLE;
                end
                default: state_d = KEY_PRESS_IDLE;
            endcase
        end
    end

    always_comb begin
        sw_run_d    = sw_run_q;
        tmr_run_d   = tmr_run_q;
        sw_clr_d    = 1'b0;
        tmr_clr_d   = 1'b0;
        inc_min_d   = 1'b0;
        inc_hr_d    = 1'b0;
        tmr_inc_d   = 3'b000;
        field_sel_d = field_sel_q;
        case (mode_q)
            MODE_CLOCK_SET: begin
                inc_min_d = key_press[0];
                inc_hr_d  = key_press[1];
            end
            MODE_TIMER_SET: begin
                if (key_press[0]) field_sel_d = next_field(field_sel_q);
                if (key_press[1]) tmr_inc_d = field_onehot(field_sel_q);
            end
            MODE_STOPWATCH: begin
                if (short_act) sw_run_d = ~sw_run_q;
                if (long_act) begin
                    sw_run_d = 1'b0;
                    sw_clr_d = 1'b1;
                end
            end
            MODE_TIMER: begin
                if (short_act) tmr_run_d = ~tmr_run_q;
                if (long_act) begin
                    tmr_run_d = 1'b0;
                    tmr_clr_d = 1'b1;
                end
            end
            default: ;
        endcase
        if (enter_tset) begin
            field_sel_d = FLD_H;
            tmr_run_d   = 1'b0;
        end
        // The datapath reaching zero overrides any toggle in the same cycle.
        if (timer_done) tmr_run_d = 1'b0;
    end

    always_comb begin
        div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        tick_d = (div_d == DIV_LAST);
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            sw_sync1_q  <= '0;
            sw_sync2_q  <= '0;
            mode_q      <= MODE_CLOCK;
            state_q     <= KEY_PRESS_IDLE;
            hold_q      <= '0;
            div_q       <= '0;
            tick_q      <= 1'b0;
            field_sel_q <= FLD_H;
            sw_run_q    <= 1'b0;
            tmr_run_q   <= 1'b0;
            sw_clr_q    <= 1'b0;
            tmr_clr_q   <= 1'b0;
            inc_min_q   <= 1'b0;
            inc_hr_q    <= 1'b0;
            tmr_inc_q   <= 3'b000;
        end else begin
            sw_sync1_q  <= sw;
            sw_sync2_q  <= sw_sync1_q;
            mode_q      <= mode_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
            div_q       <= div_d;
            tick_q      <= tick_d;
            field_sel_q <= field_sel_d;
            sw_run_q    <= sw_run_d;
            tmr_run_q   <= tmr_run_d;
            sw_clr_q    <= sw_clr_d;
            tmr_clr_q   <= tmr_clr_d;
            inc_min_q   <= inc_min_d;
            inc_hr_q    <= inc_hr_d;
            tmr_inc_q   <= tmr_inc_d;
        end
    end

    assign tick_1hz  = tick_q;
    assign mode      = mode_q;
    assign inc_min   = inc_min_q;
    assign inc_hr    = inc_hr_q;
    assign sw_run    = sw_run_q;
    assign sw_clr    = sw_clr_q;
    assign tmr_run   = tmr_run_q;
    assign tmr_clr   = tmr_clr_q;
    assign tmr_inc   = tmr_inc_q;
    assign field_sel = field_sel_q;
    assign blink     = (mode_q == MODE_CLOCK_SET || mode_q == MODE_TIMER_SET) ? (div_q < DIV_HALF) : 1'b1;

endmodule
